uart_baud_gen: RTL

Parametrised baud-rate generator for the UART; supersedes the fixed square-wave divider. Produces single-cycle enable ticks, not derived clocks, so TX and RX logic stays on `clk`. Both paths have runtime-programmable divisors with glitch-free update and independent enables. The RX path adds an oversampling counter with start-bit resynchronisation and a mid-bit sample strobe.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_tick_cnt.sv | 86 ++++++++
 rtl/uart_baud_gen.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants and helpers for the UART baud-rate generator.
package uart_pkg;

    localparam int unsigned DEF_CLK_FREQ   = 50000000;
    localparam int unsigned DEF_TX_BAUD    = 115200;
    localparam int unsigned DEF_RX_BAUD    = 19200;
    localparam int unsigned DEF_OVERSAMPLE = 16;

    // Smallest divisor accepted at runtime; anything below is rejected.
    localparam int unsigned MIN_DIV = 2;

    // Clock cycles per tick for a given baud rate and ticks-per-bit.
    function automatic int unsigned baud_div(input int unsigned freq,
                                             input int unsigned baud,
                                             input int unsigned os);
        return freq / (baud * os);
    endfunction

endpackage

// File: rtl/uart_tick_cnt.sv
// Programmable tick counter: active/shadow divisor pair with glitch-free
// update on the wrap cycle, registered enable and a synchronous phase clear.
module uart_tick_cnt
    import uart_pkg::*;
#(
    parameter int unsigned     DivW   = 16,
    parameter logic [DivW-1:0] DefDiv = DivW'(baud_div(DEF_CLK_FREQ, DEF_TX_BAUD, 1))
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            en_i,
    input  logic            clr_i,
    input  logic            wr_i,
    input  logic [DivW-1:0] div_i,
    output logic            tick_o
);

    logic [DivW-1:0] div_act_q, div_act_d;
    logic [DivW-1:0] div_sh_q, div_sh_d;
    logic [DivW-1:0] cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic            en_q;
    logic            run;
    logic            wrap;

    // Counting only while the enable was high last cycle and is still high.
    assign run    = en_q & en_i;
    assign wrap   = en_q & (cnt_q == div_act_q - 1'b1);
    assign tick_o = wrap;

    // Next-state: clear/disable beat wrap; a write targets the shadow while
    // running so the current period is never cut or stretched.
    always_comb begin
        div_act_d = div_act_q;
        div_sh_d  = div_sh_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;

        if (!run) begin
            cnt_d = '0;
            if (pend_q) begin
                div_act_d = div_sh_q;
                pend_d    = 1'b0;
            end
        end else if (clr_i) begin
            // Resync keeps any pending divisor for the next real wrap.
            cnt_d = '0;
        end else if (wrap) begin
            cnt_d = '0;
            if (pend_q) begin
                div_act_d = div_sh_q;
                pend_d    = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        if (wr_i) begin
            if (run) begin
                div_sh_d = div_i;
                pend_d   = 1'b1;
            end else begin
                div_act_d = div_i;
                pend_d    = 1'b0;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_act_q <= DefDiv;
            div_sh_q  <= DefDiv;
            pend_q    <= 1'b0;
            cnt_q     <= '0;
            en_q      <= 1'b0;
        end else begin
            div_act_q <= div_act_d;
            div_sh_q  <= div_sh_d;
            pend_q    <= pend_d;
            cnt_q     <= cnt_d;
            en_q      <= en_i;
        end
    end

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate generator: TX tick, RX oversample tick with mid-bit and
// end-of-bit strobes, runtime divisor configuration with error pulse.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = DEF_CLK_FREQ,
    parameter int unsigned TX_BAUD    = DEF_TX_BAUD,
    parameter int unsigned RX_BAUD    = DEF_RX_BAUD,
    parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int unsigned DIV_W      = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             tx_en_i,
    input  logic             rx_en_i,
    input  logic             rx_resync_i,
    input  logic             cfg_wr_i,
    input  logic             cfg_sel_i,
    input  logic [DIV_W-1:0] cfg_div_i,
    output logic             cfg_err_o,
    output logic             tx_tick_o,
    output logic             rx_tick_o,
    output logic             rx_sample_o,
    output logic             rx_bit_o
);

    localparam logic [DIV_W-1:0] DEF_TX_DIV = DIV_W'(baud_div(CLK_FREQ, TX_BAUD, 1));
    localparam logic [DIV_W-1:0] DEF_RX_DIV = DIV_W'(baud_div(CLK_FREQ, RX_BAUD, OVERSAMPLE));
    localparam int unsigned      OS_W       = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0]  OS_MID     = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]  OS_LAST    = OS_W'(OVERSAMPLE - 1);

    logic            div_ok;
    logic            tx_wr;
    logic            rx_wr;
    logic            rx_tick;
    logic [OS_W-1:0] os_q, os_d;
    logic            err_q, err_d;

    assign div_ok = cfg_div_i >= DIV_W'(MIN_DIV);
    assign tx_wr  = cfg_wr_i & div_ok & ~cfg_sel_i;
    assign rx_wr  = cfg_wr_i & div_ok & cfg_sel_i;
    assign err_d  = cfg_wr_i & ~div_ok;

    uart_tick_cnt #(
        .DivW   (DIV_W),
        .DefDiv (DEF_TX_DIV)
    ) u_tx_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (tx_en_i),
        .clr_i  (1'b0),
        .wr_i   (tx_wr),
        .div_i  (cfg_div_i),
        .tick_o (tx_tick_o)
    );

    uart_tick_cnt #(
        .DivW   (DIV_W),
        .DefDiv (DEF_RX_DIV)
    ) u_rx_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .en_i   (rx_en_i),
        .clr_i  (rx_resync_i),
        .wr_i   (rx_wr),
        .div_i  (cfg_div_i),
        .tick_o (rx_tick)
    );

    // Oversample position within the bit; resync and disable restart it.
    always_comb begin
        os_d = os_q;
        if (!rx_en_i || rx_resync_i) begin
            os_d = '0;
        end else if (rx_tick) begin
            os_d = (os_q == OS_LAST) ? '0 : os_q + 1'b1;
        end
    end

    // Oversample counter and config-error pulse registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            os_q  <= '0;
            err_q <= 1'b0;
        end else begin
            os_q  <= os_d;
            err_q <= err_d;
        end
    end

    assign rx_tick_o   = rx_tick;
    assign rx_sample_o = rx_tick & (os_q == OS_MID);
    assign rx_bit_o    = rx_tick & (os_q == OS_LAST);
    assign cfg_err_o   = err_q;

endmodule
